nabp_image_accumulator: RTL and testbench

Back-projection image accumulator that sits directly downstream of the image addresser. It owns the image RAM port. It kicks the addresser at the start of each projection pass and gates the addresser with `ir_enable` so that addresses track the PE domino-chain value stream. For each accepted sample it performs a pipelined read-modify-write (saturating signed add) into the image RAM, with same-address forwarding.

---
 rtl/nabp_image_accumulator.sv | 122 ++++++++++++
 tb/tb_nabp_image_accumulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nabp_image_accumulator.sv
// Back-projection image accumulator: kicks the image addresser, gates it with the PE
// stream, and does a two-stage saturating read-modify-write into the image RAM.
module nabp_image_accumulator #(
  parameter int kImageAddressLength = 12,
  parameter int kDataLength         = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           clear,
  input  logic                           pe_valid,
  input  logic [kDataLength-1:0]         pe_value,
  input  logic                           pe_last,
  output logic                           ir_kick,
  input  logic                           ir_kick_ack,
  output logic                           ir_enable,
  input  logic [kImageAddressLength-1:0] ir_addr,
  output logic                           ram_rd_en,
  output logic [kImageAddressLength-1:0] ram_rd_addr,
  input  logic [kDataLength-1:0]         ram_rd_data,
  output logic                           ram_wr_en,
  output logic [kImageAddressLength-1:0] ram_wr_addr,
  output logic [kDataLength-1:0]         ram_wr_data,
  output logic                           busy,
  output logic                           pass_done
);

  typedef enum logic [1:0] {IDLE, KICK, STREAM, DRAIN} state_e;

  state_e                         state_q, state_d;
  logic                           clear_q, clear_d;
  logic                           s1_valid_q, s1_valid_d;
  logic                           s1_last_q, s1_last_d;
  logic [kImageAddressLength-1:0] s1_addr_q, s1_addr_d;
  logic [kDataLength-1:0]         s1_value_q, s1_value_d;
  logic                           fwd_q, fwd_d;
  logic [kDataLength-1:0]         fwd_data_q, fwd_data_d;

  logic                           accept;
  logic [kDataLength-1:0]         operand;
  logic [kDataLength:0]           sum_wide;
  logic [kDataLength-1:0]         sum_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      clear_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_value_q <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      clear_q    <= clear_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_addr_q  <= s1_addr_d;
      s1_value_q <= s1_value_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clear_d   = clear_q;
    ir_kick   = 1'b0;
    ir_enable = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear_d = clear;
          state_d = KICK;
        end
      end
      KICK: begin
        ir_kick = 1'b1;
        if (ir_kick_ack) state_d = STREAM;
      end
      STREAM: begin
        ir_enable = pe_valid;
        accept    = pe_valid;
        if (pe_valid && pe_last) state_d = DRAIN;
      end
      // Nothing enters S1 here, so S1 is empty after this cycle's write.
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    operand  = fwd_q ? fwd_data_q : ram_rd_data;
    sum_wide = {operand[kDataLength-1], operand} + {s1_value_q[kDataLength-1], s1_value_q};
    if (sum_wide[kDataLength] != sum_wide[kDataLength-1])
      sum_sat = sum_wide[kDataLength] ? {1'b1, {(kDataLength-1){1'b0}}}
                                      : {1'b0, {(kDataLength-1){1'b1}}};
    else
      sum_sat = sum_wide[kDataLength-1:0];
  end

  always_comb begin
    s1_valid_d  = accept;
    s1_last_d   = accept ? pe_last  : s1_last_q;
    s1_addr_d   = accept ? ir_addr  : s1_addr_q;
    s1_value_d  = accept ? pe_value : s1_value_q;
    ram_rd_en   = accept;
    ram_rd_addr = accept ? ir_addr : '0;
    ram_wr_en   = s1_valid_q;
    ram_wr_addr = s1_valid_q ? s1_addr_q : '0;
    ram_wr_data = '0;
    if (s1_valid_q) ram_wr_data = clear_q ? s1_value_q : sum_sat;
    pass_done   = s1_valid_q && s1_last_q;
    busy        = (state_q != IDLE);
    // The RAM returns old data on a same-cycle collision, so carry the new word over.
    fwd_d       = accept && s1_valid_q && (ir_addr == s1_addr_q);
    fwd_data_d  = ram_wr_data;
  end

endmodule

// File: tb/tb_nabp_image_accumulator.sv
// Bench for nabp_image_accumulator: synchronous RAM model, pass-level reference model
// checked every cycle, and literal RAM-content checks after each directed pass.
module tb_nabp_image_accumulator;
  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, start, clear, pe_valid, pe_last, ir_kick_ack;
  logic [DW-1:0] pe_value;
  logic [AW-1:0] ir_addr;
  logic          ir_kick, ir_enable, ram_rd_en, ram_wr_en, busy, pass_done;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic [DW-1:0] ram_rd_data, ram_wr_data;

  nabp_image_accumulator #(.kImageAddressLength(AW), .kDataLength(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .pe_valid(pe_valid), .pe_value(pe_value), .pe_last(pe_last),
    .ir_kick(ir_kick), .ir_kick_ack(ir_kick_ack), .ir_enable(ir_enable), .ir_addr(ir_addr),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .busy(busy), .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  // Image RAM: synchronous read, read-during-write returns the old word.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: image contents plus pass-level bookkeeping.
  logic [DW-1:0] gold [0:(1<<AW)-1];
  logic          m_busy = 0, m_kick = 0, m_stream = 0, m_drain = 0, m_clear = 0;
  logic          m_wr_v = 0, m_wr_last = 0;
  logic [AW-1:0] m_wr_addr = '0;
  logic [DW-1:0] m_wr_data = '0;
  int            wr_count = 0;
  logic [DW-1:0] wlog [$];

  always @(negedge clk) begin
    logic b0, e_en, nv, nlast;
    logic [AW-1:0] naddr;
    int s;
    if (reset) begin
      chk("rst_busy", busy, 0);      chk("rst_kick", ir_kick, 0);
      chk("rst_en", ir_enable, 0);   chk("rst_rd_en", ram_rd_en, 0);
      chk("rst_wr_en", ram_wr_en, 0); chk("rst_done", pass_done, 0);
      chk("rst_wr_addr", ram_wr_addr, 0); chk("rst_wr_data", ram_wr_data, 0);
      m_busy = 0; m_kick = 0; m_stream = 0; m_drain = 0; m_wr_v = 0;
    end else begin
      e_en = m_stream && pe_valid;
      chk("busy", busy, m_busy);
      chk("ir_kick", ir_kick, m_kick);
      chk("ir_enable", ir_enable, e_en);
      chk("rd_en", ram_rd_en, e_en);
      if (e_en) chk("rd_addr", ram_rd_addr, ir_addr);
      chk("wr_en", ram_wr_en, m_wr_v);
      chk("pass_done", pass_done, m_wr_v && m_wr_last);
      if (ram_wr_en) begin
        wr_count++;
        wlog.push_back(ram_wr_data);
      end
      if (m_wr_v) begin
        chk("wr_addr", ram_wr_addr, m_wr_addr);
        chk("wr_data", ram_wr_data, m_wr_data);
        gold[m_wr_addr] = m_wr_data;
      end
      b0 = m_busy;
      nv = 0; nlast = 0; naddr = '0; s = 0;
      if (m_drain) begin
        m_drain = 0;
        m_busy  = 0;
      end
      if (e_en) begin
        if (m_clear) s = $signed(pe_value);
        else         s = $signed(gold[ir_addr]) + $signed(pe_value);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        nv = 1; naddr = ir_addr; nlast = pe_last;
        if (pe_last) begin
          m_stream = 0;
          m_drain  = 1;
        end
      end
      if (m_kick && ir_kick_ack) begin
        m_kick   = 0;
        m_stream = 1;
      end
      if (!b0 && start) begin
        m_busy  = 1;
        m_kick  = 1;
        m_clear = clear;
      end
      m_wr_v = nv; m_wr_addr = naddr; m_wr_data = s[DW-1:0]; m_wr_last = nlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic preload(input int a, input logic [DW-1:0] v);
    mem[a]  = v;
    gold[a] = v;
  endtask

  task automatic start_pass(input logic c);
    start = 1; clear = c;
    tick();
    start = 0; clear = 0;
    tick();
    ir_kick_ack = 1;
    tick();
    ir_kick_ack = 0;
  endtask

  task automatic send(input int a, input logic [DW-1:0] v, input logic last);
    pe_valid = 1; ir_addr = a[AW-1:0]; pe_value = v; pe_last = last;
    tick();
    pe_valid = 0; pe_last = 0; pe_value = '0; ir_addr = '0;
  endtask

  task automatic clear_pass(input int base);
    start_pass(1);
    send(base, 16'd5, 0);
    send(base + 1, 16'd6, 0);
    send(base + 2, 16'd7, 1);
    idle(4);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]  = '0;
      gold[i] = '0;
    end
    reset = 1; start = 0; clear = 0; pe_valid = 0; pe_value = '0; pe_last = 0;
    ir_kick_ack = 0; ir_addr = '0;
    idle(3);
    reset = 0;
    idle(2);

    // Clear pass over garbage contents.
    preload(0, 16'hAAAA); preload(1, 16'h5555); preload(2, 16'h1234);
    clear_pass(0);
    chk("clr_mem0", mem[0], 5); chk("clr_mem1", mem[1], 6); chk("clr_mem2", mem[2], 7);

    // Accumulate.
    preload(3, 16'd100);
    start_pass(0);
    send(3, 16'd20, 1);
    idle(4);
    chk("acc_mem3", mem[3], 120);
    chk("acc_gold3", gold[3], 120);

    // Forwarding: three back-to-back samples to one address.
    preload(9, 16'd10);
    wlog.delete();
    start_pass(0);
    send(9, 16'd1, 0); send(9, 16'd2, 0); send(9, 16'd3, 1);
    idle(4);
    chk("fwd_nwr", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("fwd_w0", wlog[0], 11); chk("fwd_w1", wlog[1], 13); chk("fwd_w2", wlog[2], 16);
    end
    chk("fwd_mem9", mem[9], 16);

    // Saturation at both rails.
    preload(4, 16'h7FF0); preload(5, 16'h8005);
    start_pass(0);
    send(4, 16'h0100, 0); send(5, 16'hFF00, 1);
    idle(4);
    chk("sat_pos", mem[4], 16'h7FFF);
    chk("sat_neg", mem[5], 16'h8000);

    // Stalls with a stray start during streaming.
    preload(10, 16'd1); preload(11, 16'd2);
    w0 = wr_count;
    start_pass(0);
    send(10, 16'd1, 0);
    start = 1; clear = 1;
    tick();
    start = 0; clear = 0;
    tick();
    send(11, 16'd5, 1);
    idle(6);
    chk("stall_nwr", wr_count - w0, 2);
    chk("stall_mem10", mem[10], 2);
    chk("stall_mem11", mem[11], 7);

    // Reset one cycle after an accept: the in-flight write must be dropped.
    preload(20, 16'h1234);
    w0 = wr_count;
    start_pass(1);
    pe_valid = 1; ir_addr = 12'd20; pe_value = 16'd33; pe_last = 0;
    tick();
    pe_valid = 0; pe_value = '0; ir_addr = '0;
    reset = 1;
    idle(2);
    reset = 0;
    idle(3);
    chk("rst_nwr", wr_count - w0, 0);
    chk("rst_mem20", mem[20], 16'h1234);
    clear_pass(20);
    chk("post_mem20", mem[20], 5); chk("post_mem21", mem[21], 6); chk("post_mem22", mem[22], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
